// File: rtl/fifo_2w1r.sv
// fifo_2w1r: show-ahead synchronous FIFO, two write lanes (lane 0 older),
// one read lane. Sits between fetch (pushes up to two words per cycle) and
// decode (pops one); flush drops every buffered entry on a branch redirect.
// Optional feature macro: FIFO_BYPASS_EN. When it is defined, an empty FIFO
// hands lane 0 straight to a ready consumer in the same cycle.
// Pointers carry a wrap bit, so occupancy is simply wptr - rptr.
module fifo_2w1r #(
   parameter int DATA_LEN   = 32,
   parameter int AddR_Width = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic [1:0]            wvalid,
   input  logic [DATA_LEN-1:0]   wdata0,
   input  logic [DATA_LEN-1:0]   wdata1,
   output logic                  wready,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_LEN-1:0]   rdata,
   output logic [AddR_Width:0]   count,
   output logic                  ovf_err,
   output logic                  udf_err
);

   localparam int PW    = AddR_Width + 1;
   localparam int DEPTH = 1 << AddR_Width;
   localparam logic [PW-1:0] ZERO_P  = {PW{1'b0}};
   localparam logic [PW-1:0] ONE_P   = PW'(1);
   localparam logic [PW-1:0] TWO_P   = PW'(2);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [DATA_LEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]       wptr_q, wptr_d;
   logic [PW-1:0]       rptr_q, rptr_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;

   logic                empty_s;
   logic                byp_s;
   logic                push_s;
   logic                pop_s;
   logic                wr0_en_s;
   logic                wr1_en_s;
   logic [DATA_LEN-1:0] wr0_data_s;
   logic [PW-1:0]       wptr1_s;
   logic [PW-1:0]       wptr_inc_s;

   // Status, handshakes, head data and next-state pointer/flag logic.
   always_comb begin
      count   = wptr_q - rptr_q;
      empty_s = (count == ZERO_P);
      // Two free slots are required even for a single-lane push.
      wready  = (count <= (DEPTH_P - TWO_P));

      byp_s = 1'b0;
`ifdef FIFO_BYPASS_EN
      byp_s = empty_s & ~flush & wvalid[0] & rready;
`endif

      rvalid = ~empty_s | byp_s;
      rdata  = byp_s ? wdata0 : mem_q[rptr_q[AddR_Width-1:0]];

      // wvalid = 2'b10 is not contiguous and is ignored; lane 0 gates everything.
      push_s = wvalid[0] & wready & ~flush;
      // A bypassed lane 0 is consumed without touching rptr.
      pop_s  = rready & ~empty_s & ~flush;

      // In bypass, lane 1 (if any) takes the slot lane 0 would have used.
      wr0_en_s   = push_s & (~byp_s | wvalid[1]);
      wr1_en_s   = push_s & ~byp_s & wvalid[1];
      wr0_data_s = byp_s ? wdata1 : wdata0;
      wptr1_s    = wptr_q + ONE_P;

      if (wr1_en_s) begin
         wptr_inc_s = TWO_P;
      end else if (wr0_en_s) begin
         wptr_inc_s = ONE_P;
      end else begin
         wptr_inc_s = ZERO_P;
      end

      if (flush) begin
         wptr_d = rptr_q;
      end else begin
         wptr_d = wptr_q + wptr_inc_s;
      end

      if (pop_s) begin
         rptr_d = rptr_q + ONE_P;
      end else begin
         rptr_d = rptr_q;
      end

      ovf_d = ovf_q | (wvalid[0] & ~wready & ~flush);
      udf_d = udf_q | (rready & ~rvalid & ~flush);

      ovf_err = ovf_q;
      udf_err = udf_q;
   end

   // Pointer and sticky error registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q <= ZERO_P;
         rptr_q <= ZERO_P;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // Entry storage; deliberately not reset, contents are only read when valid.
   always_ff @(posedge clk) begin
      if (wr0_en_s) begin
         mem_q[wptr_q[AddR_Width-1:0]] <= wr0_data_s;
      end
      if (wr1_en_s) begin
         mem_q[wptr1_s[AddR_Width-1:0]] <= wdata1;
      end
   end

endmodule

// File: tb/tb_fifo_2w1r.sv
// Self-checking bench for fifo_2w1r (depth 16, 32-bit entries).
// A scoreboard queue holds the entries the bench expects the FIFO to contain;
// every pop compares rdata with the queue head. Scenario tasks add their own
// checks on count, handshakes and error flags.
module tb_fifo_2w1r;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic [1:0]  wvalid;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic        wready;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [4:0]  count;
   logic        ovf_err;
   logic        udf_err;

   int          vectors;
   int          errors;
   logic [31:0] sb[$];

   fifo_2w1r #(.DATA_LEN(32), .AddR_Width(4)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (flush),
      .wvalid  (wvalid),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .wready  (wready),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .count   (count),
      .ovf_err (ovf_err),
      .udf_err (udf_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // One clock of stimulus; scoreboard updated from the bench's own occupancy.
   task automatic cycle(input logic [1:0] wv, input logic [31:0] d0, input logic [31:0] d1,
                        input logic rr, input logic fl);
      int          occ;
      bit          byp;
      bit          acc_w;
      bit          do_pop;
      logic [31:0] exp;
      occ = sb.size();
      wvalid = wv; wdata0 = d0; wdata1 = d1; rready = rr; flush = fl;
      #1;
      byp = 1'b0;
`ifdef FIFO_BYPASS_EN
      byp = (occ == 0) && !fl && wv[0] && rr;
`endif
      acc_w  = wv[0] && ((DEPTH - occ) >= 2) && !fl;
      do_pop = rr && ((occ != 0) || byp) && !fl;
      if (do_pop) begin
         exp = byp ? d0 : sb[0];
         vectors++;
         if (rvalid !== 1'b1 || rdata !== exp) begin
            errors++;
            $display("FAIL pop_data: rvalid=%b rdata=%h, want rvalid=1 rdata=%h", rvalid, rdata, exp);
         end
         if (!byp) void'(sb.pop_front());
      end
      if (fl) begin
         sb.delete();
      end else if (acc_w) begin
         if (!byp) sb.push_back(d0);
         if (wv[1]) sb.push_back(d1);
      end
      @(posedge clk);
      #1;
      wvalid = 2'b00; rready = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; wvalid = 2'b00; rready = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      vectors++; if (wready !== 1'b1)  begin errors++; $display("FAIL reset_wready: got %b want 1", wready); end
      vectors++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
      vectors++; if (udf_err !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b want 0", udf_err); end
   endtask

   task automatic test_basic();
      logic [4:0] exp_cnt [4];
      exp_cnt[0] = 5'd3; exp_cnt[1] = 5'd2; exp_cnt[2] = 5'd1; exp_cnt[3] = 5'd0;
      do_reset();
      cycle(2'b11, 32'd1, 32'd2, 1'b0, 1'b0);
      vectors++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count2: got %0d want 2", count); end
      vectors++; if (rvalid !== 1'b1 || rdata !== 32'd1) begin
         errors++; $display("FAIL basic_latency: rvalid=%b rdata=%0d want 1/1", rvalid, rdata);
      end
      cycle(2'b11, 32'd3, 32'd4, 1'b0, 1'b0);
      vectors++; if (count !== 5'd4) begin errors++; $display("FAIL basic_count4: got %0d want 4", count); end
      for (int i = 0; i < 4; i++) begin
         cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
         vectors++;
         if (count !== exp_cnt[i]) begin
            errors++; $display("FAIL basic_pop_count: pop %0d got %0d want %0d", i, count, exp_cnt[i]);
         end
      end
      vectors++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_rvalid_drop: got %b want 0", rvalid); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 7; i++) cycle(2'b11, 32'(100 + 2*i), 32'(101 + 2*i), 1'b0, 1'b0);
      vectors++; if (count !== 5'd14) begin errors++; $display("FAIL full_count14: got %0d want 14", count); end
      vectors++; if (wready !== 1'b1) begin errors++; $display("FAIL full_wready14: got %b want 1", wready); end
      cycle(2'b11, 32'd114, 32'd115, 1'b0, 1'b0);
      vectors++; if (count !== 5'd16) begin errors++; $display("FAIL full_count16: got %0d want 16", count); end
      vectors++; if (wready !== 1'b0) begin errors++; $display("FAIL full_wready16: got %b want 0", wready); end
      vectors++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b want 0", ovf_err); end
      cycle(2'b11, 32'd900, 32'd901, 1'b0, 1'b0);
      vectors++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b want 1", ovf_err); end
      vectors++; if (count !== 5'd16) begin errors++; $display("FAIL full_count_hold: got %0d want 16", count); end
      vectors++; if (udf_err !== 1'b0) begin errors++; $display("FAIL full_udf: got %b want 0", udf_err); end
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      vectors++; if (wready !== 1'b0) begin errors++; $display("FAIL full_wready15: got %b want 0", wready); end
      for (int i = 0; i < 15; i++) cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      vectors++; if (count !== 5'd0 || rvalid !== 1'b0) begin
         errors++; $display("FAIL full_drain: count=%0d rvalid=%b want 0/0", count, rvalid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(2'b11, 32'd500, 32'd501, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cycle(2'b01, 32'(600 + i), 32'd0, 1'b1, 1'b0);
         vectors++;
         if (count !== 5'd2) begin errors++; $display("FAIL wrap_count: iter %0d got %0d want 2", i, count); end
      end
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      vectors++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_drain: got %0d want 0", count); end
   endtask

   task automatic test_illegal_lanes();
      do_reset();
      cycle(2'b10, 32'd77, 32'd78, 1'b0, 1'b0);
      vectors++; if (count !== 5'd0 || ovf_err !== 1'b0) begin
         errors++; $display("FAIL lanes_10: count=%0d ovf=%b want 0/0", count, ovf_err);
      end
      cycle(2'b01, 32'd79, 32'd80, 1'b0, 1'b0);
      vectors++; if (count !== 5'd1) begin errors++; $display("FAIL lanes_01: got %0d want 1", count); end
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      do_reset();
      cycle(2'b11, 32'hA, 32'hB, 1'b0, 1'b0);
      cycle(2'b01, 32'hC, 32'd0, 1'b0, 1'b0);
      vectors++; if (count !== 5'd3) begin errors++; $display("FAIL flush_pre: got %0d want 3", count); end
      cycle(2'b11, 32'hD, 32'hE, 1'b1, 1'b1);
      vectors++; if (count !== 5'd0)  begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
      vectors++; if (rvalid !== 1'b0) begin errors++; $display("FAIL flush_rvalid: got %b want 0", rvalid); end
      vectors++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin
         errors++; $display("FAIL flush_flags: ovf=%b udf=%b want 0/0", ovf_err, udf_err);
      end
      cycle(2'b01, 32'hF, 32'd0, 1'b0, 1'b0);
      vectors++; if (count !== 5'd1) begin errors++; $display("FAIL flush_repush: got %0d want 1", count); end
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_underflow();
      do_reset();
`ifdef FIFO_BYPASS_EN
      cycle(2'b11, 32'h5A5A, 32'hA5A5, 1'b1, 1'b0);
      vectors++; if (udf_err !== 1'b0) begin errors++; $display("FAIL byp_udf: got %b want 0", udf_err); end
      vectors++; if (count !== 5'd1)   begin errors++; $display("FAIL byp_count: got %0d want 1", count); end
      vectors++; if (rdata !== 32'hA5A5) begin errors++; $display("FAIL byp_head: got %h want a5a5", rdata); end
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
`else
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      vectors++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_set: got %b want 1", udf_err); end
      vectors++; if (count !== 5'd0)   begin errors++; $display("FAIL udf_count: got %0d want 0", count); end
`endif
   endtask

   task automatic test_midreset();
      do_reset();
      cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      vectors++; if (udf_err !== 1'b1) begin errors++; $display("FAIL mid_udf_pre: got %b want 1", udf_err); end
      for (int i = 0; i < 4; i++) cycle(2'b11, 32'(700 + 2*i), 32'(701 + 2*i), 1'b0, 1'b0);
      cycle(2'b01, 32'd710, 32'd0, 1'b0, 1'b0);
      vectors++; if (count !== 5'd9) begin errors++; $display("FAIL mid_count9: got %0d want 9", count); end
      rstn = 1'b0; wvalid = 2'b11; wdata0 = 32'd1; wdata1 = 32'd2; rready = 1'b1;
      @(posedge clk);
      #1;
      rstn = 1'b1; wvalid = 2'b00; rready = 1'b0;
      sb.delete();
      vectors++; if (count !== 5'd0)   begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
      vectors++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL mid_rvalid: got %b want 0", rvalid); end
      vectors++; if (wready !== 1'b1)  begin errors++; $display("FAIL mid_wready: got %b want 1", wready); end
      vectors++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin
         errors++; $display("FAIL mid_flags: ovf=%b udf=%b want 0/0", ovf_err, udf_err);
      end
   endtask

   // Test sequence.
   initial begin
      clk = 1'b0; rstn = 1'b0; flush = 1'b0; wvalid = 2'b00; rready = 1'b0;
      wdata0 = 32'd0; wdata1 = 32'd0;
      vectors = 0; errors = 0;
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_illegal_lanes();
      test_flush();
      test_underflow();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/fifo_2w1r.md
# fifo_2w1r

Show-ahead synchronous FIFO with two write lanes and one read lane, the next generation of the single-lane core FIFO. It sits between the fetch unit and decode: fetch pushes up to two instructions per cycle, decode pops one, and a branch redirect flushes all buffered entries. It adds a full indication, an occupancy count, valid/ready handshakes and sticky error flags.

## Interface
- DATA_LEN, 32: bits per entry
- AddR_Width, 4: log2 of depth; depth = 2**AddR_Width, minimum 2 (depth 4)

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- flush  in  1  discard all entries
- wvalid  in  2  write lane valids; bit0 = lane 0 (older), bit1 = lane 1 (younger)
- wdata0  in  DATA_LEN  lane 0 data
- wdata1  in  DATA_LEN  lane 1 data
- wready  out  1  at least 2 free slots
- rvalid  out  1  head entry present
- rready  in  1  consumer takes head this cycle
- rdata  out  DATA_LEN  head entry, combinational from storage
- count  out  AddR_Width+1  current occupancy, 0..depth
- ovf_err  out  1  sticky: write attempted while wready=0
- udf_err  out  1  sticky: rready while rvalid=0

## Operation
- Pointers are AddR_Width+1 bits with a wrap bit. Empty: pointers equal. Full: low bits equal and wrap bits differ. Index uses the low AddR_Width bits. Pointers wrap modulo 2*depth.
- Write lanes are contiguous. 2'b10 is illegal and treated as 2'b00; it does not set ovf_err.
- Push fires when wvalid!=0 and wready=1. Lane 0 is written at wptr and lane 1 at wptr+1 (mod depth). wptr advances by 1 or 2.
- wready = (depth - count) >= 2. This is conservative: a single push is refused when only one slot is free.
- Pop fires when rready=1 and rvalid=1. rptr advances by 1.
- count_next = count + pushed - popped. The arithmetic is exact in AddR_Width+1 bits, and count never exceeds depth.
- Simultaneous push and pop are both honoured, with wready and rvalid evaluated on pre-edge state.
- flush=1 has priority over push and pop. Next cycle: wptr=rptr, count=0, rvalid=0. Storage contents are don't-care. Error flags are unaffected.
- ovf_err is set when wvalid!=0 and wready=0 and flush=0. udf_err is set when rready=1 and rvalid=0 and flush=0. Both error flags clear only on reset.
- Reset (rstn=0 at an edge), including mid-operation: pointers=0, count=0, rvalid=0, ovf_err=0, udf_err=0, wready=1. Storage is not reset, so rdata is undefined while empty.

## Timing
- Write-to-read latency is 1 cycle: data pushed at edge N appears on rdata with rvalid=1 after edge N.
- rdata, rvalid, wready and count are derived only from registered state. They do not depend combinationally on wvalid or rready. The exception is bypass mode, below.
- A flush at edge N suppresses all pushes and pops at edge N. rvalid=0 from N+1. A new push is accepted at N+1.
- Throughput: 1 pop per cycle sustained, and 2 pushes per cycle while space remains.

## Configuration
- FIFO_BYPASS_EN defined: when count=0, flush=0, wvalid[0]=1 and rready=1, rvalid=1 and rdata=wdata0 combinationally in the same cycle.
  - Lane 0 is consumed without being stored.
  - Lane 1, if valid, is stored at wptr, giving count_next=1.
  - udf_err is not set in this case.
- FIFO_BYPASS_EN undefined: rvalid depends only on state. An empty FIFO with rready=1 sets udf_err, and pushed data is visible next cycle.

## Test plan
- Reset, then push the pairs {1,2},{3,4} in 2 cycles, then pop 4 times. rdata sequence is 1,2,3,4. count goes 0,2,4,3,2,1,0. rvalid falls after the 4th pop.
- Depth 16: push 7 pairs, so count=14 and wready=1. Push 1 more pair, so count=16, wready=0 and full. Then push while full: ovf_err=1 and count stays 16.
- Wrap-around: push and pop 1 per cycle for 40 cycles. count stays constant, and data order is preserved across a pointer wrap.
- Queue holds {A,B,C}. Assert flush together with wvalid=2'b11 and rready. Next cycle: count=0 and rvalid=0, and nothing was written or popped.
- Empty FIFO, rready=1 with no push: udf_err=1 without FIFO_BYPASS_EN. With FIFO_BYPASS_EN and wvalid=2'b11, wdata={X,Y}: rdata=X the same cycle, count=1 next cycle, and head is Y.
- Assert rstn=0 mid-burst with count=9. After the edge, count=0, rvalid=0, both error flags 0 and wready=1.
